// File: rtl/ram2uart_pkg.sv
// Shared types and ASCII constants for the register/memory UART dump engine.
package common;

  typedef enum logic [2:0] {
    IDLE,
    REG_HDR,
    REG_LOAD,
    REG_LINE,
    MEM_HDR,
    MEM_LOAD,
    MEM_LINE,
    DONE
  } ram2uart_state_t;

  localparam int unsigned CHAR_W      = 6;
  localparam int unsigned LINE_CHARS  = 34;
  localparam int unsigned REG_HDR_LEN = 7;
  localparam int unsigned MEM_HDR_LEN = 6;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Element 0 is the first byte sent: "REGS:\r\n" and "MEM:\r\n".
  localparam logic [6:0][7:0] REG_HDR_BYTES = {8'h0A, 8'h0D, 8'h3A, 8'h53, 8'h47, 8'h45, 8'h52};
  localparam logic [5:0][7:0] MEM_HDR_BYTES = {8'h0A, 8'h0D, 8'h3A, 8'h4D, 8'h45, 8'h4D};

  // Character idx of a dump line: bits 31..0 as '0'/'1', then CR, LF.
  function automatic logic [7:0] line_byte(input logic [31:0] word, input logic [CHAR_W-1:0] idx);
    logic [4:0] bit_sel;
    bit_sel = 5'd31 - idx[4:0];
    if (idx < CHAR_W'(32)) begin
      return word[bit_sel] ? ASCII_1 : ASCII_0;
    end else if (idx == CHAR_W'(32)) begin
      return ASCII_CR;
    end else begin
      return ASCII_LF;
    end
  endfunction

endpackage

// File: rtl/ram2uart.sv
// Dumps the register file and data memory as ASCII binary lines to a byte-wide UART transmitter.
import common::*;

module ram2uart #(
  parameter int unsigned REG_COUNT          = 32,
  parameter int unsigned MEM_WORDS          = 64,
  parameter int unsigned DATA_ADDRESS_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [4:0]                    reg_rd_addr,
  input  logic [31:0]                   reg_rd_data,
  output logic [DATA_ADDRESS_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]                   mem_rd_data,
  output logic [7:0]                    tx_byte,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned MAX_LINES = (MEM_WORDS > REG_COUNT) ? MEM_WORDS : REG_COUNT;
  localparam int unsigned LINE_W    = (MAX_LINES > 2) ? $clog2(MAX_LINES) : 1;

  ram2uart_state_t                 r_state;
  logic [CHAR_W-1:0]               r_char;
  logic [LINE_W-1:0]               r_line;
  logic [31:0]                     r_shadow;
  logic                            r_start_d;
  logic [7:0]                      r_tx_byte;
  logic                            r_tx_valid;
  logic                            r_busy;
  logic                            r_done;
  logic [4:0]                      r_reg_addr;
  logic [DATA_ADDRESS_WIDTH-1:0]   r_mem_addr;

  ram2uart_state_t                 w_state_nxt;
  logic [CHAR_W-1:0]               w_char_nxt;
  logic [LINE_W-1:0]               w_line_nxt;
  logic [31:0]                     w_shadow_nxt;
  logic [7:0]                      w_tx_byte_nxt;
  logic                            w_fire;
  logic                            w_start_edge;

  // Next-state, counters and shadow word.
  always_comb begin
    w_state_nxt  = r_state;
    w_char_nxt   = r_char;
    w_line_nxt   = r_line;
    w_shadow_nxt = r_shadow;
    w_fire       = r_tx_valid & tx_ready;
    w_start_edge = start & ~r_start_d;

    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = REG_HDR;
          w_char_nxt  = '0;
          w_line_nxt  = '0;
        end
      end
      REG_HDR: begin
        if (w_fire) begin
          if (r_char == CHAR_W'(REG_HDR_LEN - 1)) begin
            w_state_nxt = REG_LOAD;
            w_char_nxt  = '0;
          end else begin
            w_char_nxt = r_char + CHAR_W'(1);
          end
        end
      end
      REG_LOAD: begin
        w_shadow_nxt = reg_rd_data;
        w_state_nxt  = REG_LINE;
      end
      REG_LINE: begin
        if (w_fire) begin
          if (r_char == CHAR_W'(LINE_CHARS - 1)) begin
            w_char_nxt = '0;
            if (r_line == LINE_W'(REG_COUNT - 1)) begin
              w_state_nxt = MEM_HDR;
              w_line_nxt  = '0;
            end else begin
              w_state_nxt = REG_LOAD;
              w_line_nxt  = r_line + LINE_W'(1);
            end
          end else begin
            w_char_nxt = r_char + CHAR_W'(1);
          end
        end
      end
      MEM_HDR: begin
        if (w_fire) begin
          if (r_char == CHAR_W'(MEM_HDR_LEN - 1)) begin
            w_state_nxt = MEM_LOAD;
            w_char_nxt  = '0;
          end else begin
            w_char_nxt = r_char + CHAR_W'(1);
          end
        end
      end
      MEM_LOAD: begin
        w_shadow_nxt = mem_rd_data;
        w_state_nxt  = MEM_LINE;
      end
      MEM_LINE: begin
        if (w_fire) begin
          if (r_char == CHAR_W'(LINE_CHARS - 1)) begin
            w_char_nxt = '0;
            if (r_line == LINE_W'(MEM_WORDS - 1)) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = MEM_LOAD;
              w_line_nxt  = r_line + LINE_W'(1);
            end
          end else begin
            w_char_nxt = r_char + CHAR_W'(1);
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte to present next cycle, decoded from the next state so tx_byte is a register.
  always_comb begin
    w_tx_byte_nxt = 8'h00;
    case (w_state_nxt)
      REG_HDR:            w_tx_byte_nxt = REG_HDR_BYTES[w_char_nxt[2:0]];
      MEM_HDR:            w_tx_byte_nxt = MEM_HDR_BYTES[w_char_nxt[2:0]];
      REG_LINE, MEM_LINE: w_tx_byte_nxt = line_byte(w_shadow_nxt, w_char_nxt);
      default:            w_tx_byte_nxt = 8'h00;
    endcase
  end

  // State and registered outputs; start history resets high to ignore a held request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_char     <= '0;
      r_line     <= '0;
      r_shadow   <= '0;
      r_start_d  <= 1'b1;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reg_addr <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_char     <= w_char_nxt;
      r_line     <= w_line_nxt;
      r_shadow   <= w_shadow_nxt;
      r_start_d  <= start;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_valid <= (w_state_nxt == REG_HDR) || (w_state_nxt == REG_LINE) ||
                    (w_state_nxt == MEM_HDR) || (w_state_nxt == MEM_LINE);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      r_reg_addr <= 5'(w_line_nxt);
      r_mem_addr <= DATA_ADDRESS_WIDTH'(w_line_nxt);
    end
  end

  assign reg_rd_addr = r_reg_addr;
  assign mem_rd_addr = r_mem_addr;
  assign tx_byte     = r_tx_byte;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_ram2uart.sv
// Randomized bench for ram2uart: byte stream checked against a queue model built from the memory contents.
module tb_ram2uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b1;
  logic        tx_ready = 1'b0;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [5:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  logic [7:0]  exp_q [$];
  bit          gap_q [$];
  logic [7:0]  got   [4096];

  int n_cmp = 0;
  int n_err = 0;
  int rx_idx = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit prev_fire = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  ram2uart dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign reg_rd_data = regs[reg_rd_addr];
  assign mem_rd_data = mem[mem_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b, input bit first_of_line);
    exp_q.push_back(b);
    gap_q.push_back(first_of_line);
  endfunction

  // Expected dump: headers, then one 34-byte line per word; a LOAD bubble precedes every line.
  function automatic void build_model();
    logic [7:0] rh [7];
    logic [7:0] mh [6];
    rh = '{8'h52, 8'h45, 8'h47, 8'h53, 8'h3A, 8'h0D, 8'h0A};
    mh = '{8'h4D, 8'h45, 8'h4D, 8'h3A, 8'h0D, 8'h0A};
    exp_q.delete();
    gap_q.delete();
    for (int i = 0; i < 7; i++) push_byte(rh[i], 1'b0);
    for (int r = 0; r < 32; r++) begin
      for (int b = 31; b >= 0; b--) push_byte(regs[r][b] ? 8'h31 : 8'h30, b == 31);
      push_byte(8'h0D, 1'b0);
      push_byte(8'h0A, 1'b0);
    end
    for (int i = 0; i < 6; i++) push_byte(mh[i], 1'b0);
    for (int m = 0; m < 64; m++) begin
      for (int b = 31; b >= 0; b--) push_byte(mem[m][b] ? 8'h31 : 8'h30, b == 31);
      push_byte(8'h0D, 1'b0);
      push_byte(8'h0A, 1'b0);
    end
  endfunction

  // tx_ready patterns: always, 3 low / 1 high, random.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 4) == 3);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst || !chk_en) begin
      prev_fire  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_byte", 32'(tx_byte), 32'(prev_byte));
      end else if (prev_fire && rx_idx < exp_q.size()) begin
        chk($sformatf("valid_after_byte%0d", rx_idx), 32'(tx_valid), 32'(!gap_q[rx_idx]));
      end
      if (tx_valid) chk("busy_with_valid", 32'(busy), 32'd1);
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(rx_idx), 32'(exp_q.size()));
        chk("done_busy", 32'(busy), 32'd1);
      end
      prev_fire  = tx_valid && tx_ready;
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      if (tx_valid && tx_ready) begin
        if (rx_idx < exp_q.size()) begin
          chk($sformatf("byte%0d", rx_idx), 32'(tx_byte), 32'(exp_q[rx_idx]));
          got[rx_idx] = tx_byte;
        end else begin
          chk("extra_byte", 32'(rx_idx), 32'(exp_q.size()));
        end
        rx_idx++;
      end
    end
  end

  task automatic begin_dump();
    build_model();
    rx_idx   = 0;
    done_cnt = 0;
    chk_en   = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (rx_idx < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (rx_idx < n) chk("byte_wait_timeout", 32'(rx_idx), 32'(n));
  endtask

  task automatic finish_dump();
    int c;
    c = 0;
    while (done_cnt == 0 && c < 20000) begin
      @(negedge clk); #1;
      c++;
    end
    if (done_cnt == 0) chk("dump_timeout", 32'(done_cnt), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("byte_count", 32'(rx_idx), 32'd3277);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("idle_after_dump", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    regs[1] = 32'h8000_0001;

    // Reset values, then release with start held high: no dump may begin.
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reg_addr", 32'(reg_rd_addr), 32'd0);
    chk("rst_mem_addr", 32'(mem_rd_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held_start_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // Single pulse, always ready; pin the model and the DUT with hand-computed bytes.
    ready_mode = 0;
    begin_dump();
    chk("model_len", 32'(exp_q.size()), 32'd3277);
    chk("model_first", 32'(exp_q[0]), 32'h52);
    chk("model_memhdr", 32'(exp_q[1095]), 32'h4D);
    chk("model_r1_b31", 32'(exp_q[41]), 32'h31);
    chk("model_r1_b0", 32'(exp_q[72]), 32'h31);
    finish_dump();
    chk("reg1_first", 32'(got[41]), 32'h31);
    for (int i = 42; i < 72; i++) chk($sformatf("reg1_zero%0d", i), 32'(got[i]), 32'h30);
    chk("reg1_last", 32'(got[72]), 32'h31);
    chk("reg1_cr", 32'(got[73]), 32'h0D);
    chk("reg1_lf", 32'(got[74]), 32'h0A);

    // Back-pressure: 3 cycles low / 1 high.
    ready_mode = 1;
    begin_dump();
    finish_dump();

    // Start held high for 5000 cycles: one dump only.
    ready_mode = 0;
    build_model();
    rx_idx   = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    repeat (5000) @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    chk("held_byte_count", 32'(rx_idx), 32'd3277);
    chk("held_done_pulses", 32'(done_cnt), 32'd1);

    // Reset mid-dump after 500 bytes, then restart from the top.
    begin_dump();
    wait_bytes(500, 2000);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_byte", 32'(tx_byte), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_reg_addr", 32'(reg_rd_addr), 32'd0);
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    begin_dump();
    finish_dump();
    chk("restart_first", 32'(got[0]), 32'h52);

    // Random contents, random ready, all-ones last memory word; a start edge mid-memory is ignored.
    ready_mode = 2;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 63; i++) mem[i] = $urandom;
    mem[63] = 32'hFFFF_FFFF;
    begin_dump();
    wait_bytes(1101 + 34 * 10 + 5, 10000);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_dump();
    for (int i = 0; i < 32; i++) chk($sformatf("last_line_bit%0d", i), 32'(got[3243 + i]), 32'h31);
    chk("last_cr", 32'(got[3275]), 32'h0D);
    chk("last_lf", 32'(got[3276]), 32'h0A);
    repeat (100) @(negedge clk);
    chk("no_second_dump_busy", 32'(busy), 32'd0);
    chk("no_second_dump_bytes", 32'(rx_idx), 32'd3277);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram2uart.md
RAM2UART -- requirements
Module: ram2uart

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of register-file words dumped.
REQ-002 SHALL have parameter MEM_WORDS, default 64, number of data-memory words dumped.
REQ-003 SHALL have parameter DATA_ADDRESS_WIDTH, default 6, data-memory address width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  dump request (level); only its rising edge is acted on.
REQ-007 SHALL have port reg_rd_addr  output  5  register-file read address.
REQ-008 SHALL have port reg_rd_data  input  32  register-file read data, combinational from reg_rd_addr.
REQ-009 SHALL have port mem_rd_addr  output  DATA_ADDRESS_WIDTH  data-memory read address.
REQ-010 SHALL have port mem_rd_data  input  32  data-memory read data, combinational from mem_rd_addr.
REQ-011 SHALL have port tx_byte  output  8  byte offered to uart_tx.
REQ-012 SHALL have port tx_valid  output  1  tx_byte is valid.
REQ-013 SHALL have port tx_ready  input  1  uart_tx accepts a byte this cycle.
REQ-014 SHALL have port busy  output  1  dump in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-016 SHALL start a dump on a cycle where start=1 and start was 0 in the previous cycle while in IDLE; edges seen while busy are ignored.
REQ-017 SHALL emit, in order: "REGS:\r\n" (52 45 47 53 3A 0D 0A), REG_COUNT lines, "MEM:\r\n" (4D 45 4D 3A 0D 0A), MEM_WORDS lines.
REQ-018 SHALL format each line as 32 ASCII bytes, bit 31 first down to bit 0, 0x30 for 0 and 0x31 for 1, then 0x0D, 0x0A (34 bytes).
REQ-019 SHALL use FSM states IDLE, REG_HDR, REG_LOAD, REG_LINE, MEM_HDR, MEM_LOAD, MEM_LINE, DONE.
REQ-020 SHALL transition IDLE->REG_HDR on start edge; REG_HDR->REG_LOAD after 7th byte accepted; REG_LOAD->REG_LINE after one cycle; REG_LINE->REG_LOAD after 34th byte if more registers remain, else ->MEM_HDR; MEM_* likewise; last MEM_LINE byte ->DONE; DONE->IDLE after one cycle.
REQ-021 SHALL drive reg_rd_addr/mem_rd_addr from the line counter and latch read data into a 32-bit shadow word in the LOAD cycle; tx_valid=0 in LOAD states.
REQ-022 SHALL transfer a byte only on a cycle with tx_valid=1 and tx_ready=1; tx_byte SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-023 SHALL assert tx_valid continuously in HDR and LINE states (no bubbles between bytes within a header or line).
REQ-024 SHALL keep per-line character counter 0..33 and line counter 0..MEM_WORDS-1, both cleared on entry to each header state.
REQ-025 SHALL produce exactly 7 + 34*REG_COUNT + 6 + 34*MEM_WORDS bytes per dump (3277 at defaults).
REQ-026 SHALL assert busy in every state except IDLE; done=1 only in DONE.

Reset
REQ-027 SHALL, on rst=0 at any time including mid-dump, immediately force IDLE, tx_valid=0, tx_byte=0, busy=0, done=0, addresses=0, counters and shadow word=0.
REQ-028 SHALL reset the start-edge register to 1, so start held high through reset release does not trigger a dump.

Structure
REQ-029 SHALL place the state enum ram2uart_state_t and the ASCII header/newline constant arrays in package common.
REQ-030 SHALL be a single module with no sub-modules; edge detector and bit-to-ASCII mux inline.

Verification
REQ-031 SHALL verify: reg[1]=0x80000001, others 0, mem all 0, tx_ready=1, start pulse -> 3277 bytes, reg line 1 = "1"+30x"0"+"1"+0D 0A, done pulses once.
REQ-032 SHALL verify: tx_ready toggled 3 cycles low / 1 high -> tx_byte constant while stalled, byte stream identical to REQ-031 case.
REQ-033 SHALL verify: start held high 5000 cycles -> exactly one dump, one done pulse.
REQ-034 SHALL verify: rst=0 asserted after 500 bytes -> tx_valid=0 and busy=0 same cycle; new start edge -> stream restarts with 0x52.
REQ-035 SHALL verify: mem[63]=0xFFFFFFFF -> final 34 bytes are 32x 0x31, 0D, 0A, then DONE.
REQ-036 SHALL verify: start edge during MEM_LINE -> ignored, byte count unchanged.
